// File: rtl/add_sub_multiciclo.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operation is processed CHUNK bits per clock
// through a registered carry chain. A START/BUSY/DONE handshake lets the ULA control FSM
// launch an operation and wait for completion. Flags are registered alongside the result,
// so outputs only ever change at completion or reset.
module add_sub_multiciclo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_i,       // synchronous, active-high
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic [WIDTH-1:0] resultado_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFim} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;          // B already inverted for subtraction
  logic             c_q, c_d;          // carry between chunks
  logic [KW-1:0]    k_q, k_d;          // chunk index
  logic [WIDTH-1:0] work_q, work_d;    // partial sum, never exposed
  logic [WIDTH-1:0] resultado_q, resultado_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  int unsigned      k_idx;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  // Chunk adder: one CHUNK-wide slice of A + Bx plus the registered carry.
  always_comb begin
    k_idx      = 32'(k_q) * CHUNK;
    last_chunk = (k_q == KW'(N - 1));
    chunk_sum  = {1'b0, a_q[k_idx +: CHUNK]} + {1'b0, b_q[k_idx +: CHUNK]}
               + {{CHUNK{1'b0}}, c_q};
  end

  // Next-state and datapath update; outputs move only on the last chunk.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    k_d         = k_q;
    work_d      = work_q;
    resultado_d = resultado_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: accept = start_i;
      StCalc: begin
        work_d[k_idx +: CHUNK] = chunk_sum[CHUNK-1:0];
        c_d                    = chunk_sum[CHUNK];
        k_d                    = k_q + KW'(1);
        if (last_chunk) begin
          state_d     = StFim;
          k_d         = '0;
          resultado_d = work_d;
          carry_out_d = chunk_sum[CHUNK];
          // Carry into the MSB recovered as a ^ b ^ sum at the MSB position.
          overflow_d  = chunk_sum[CHUNK]
                      ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1]);
          zero_d      = (work_d == '0);
        end
      end
      StFim: begin
        accept  = start_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Subtraction is A + ~B + ~borrow_in, so invert B and the carry-in once here.
    if (accept) begin
      state_d = StCalc;
      a_d     = a_i;
      b_d     = b_i ^ {WIDTH{sub_i}};
      c_d     = carry_in_i ^ sub_i;
      k_d     = '0;
      work_d  = '0;
    end
  end

  // State and datapath registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      k_q         <= '0;
      work_q      <= '0;
      resultado_q <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      k_q         <= k_d;
      work_q      <= work_d;
      resultado_q <= resultado_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign resultado_o = resultado_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;
  assign zero_o      = zero_q;
  assign busy_o      = (state_q == StCalc);
  assign done_o      = (state_q == StFim);

endmodule

// File: tb/tb_add_sub_multiciclo.sv
// Bench for add_sub_multiciclo: directed vectors on a CHUNK=4 instance, plus a sweep
// across CHUNK=1, 4 and 16 instances against a whole-word reference.
module tb_add_sub_multiciclo;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        start_v;
  logic              sub;
  logic [15:0]       a, b;
  logic              cin;
  logic [2:0][15:0]  res_v;
  logic [2:0]        co_v, ov_v, z_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_sub_multiciclo #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .sub_i(sub), .a_i(a), .b_i(b),
    .carry_in_i(cin), .resultado_o(res_v[0]), .carry_out_o(co_v[0]), .overflow_o(ov_v[0]),
    .zero_o(z_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0])
  );

  add_sub_multiciclo #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .sub_i(sub), .a_i(a), .b_i(b),
    .carry_in_i(cin), .resultado_o(res_v[1]), .carry_out_o(co_v[1]), .overflow_o(ov_v[1]),
    .zero_o(z_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1])
  );

  add_sub_multiciclo #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .sub_i(sub), .a_i(a), .b_i(b),
    .carry_in_i(cin), .resultado_o(res_v[2]), .carry_out_o(co_v[2]), .overflow_o(ov_v[2]),
    .zero_o(z_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2])
  );

  // Whole-word reference: {result, carry_out, overflow, zero}.
  function automatic logic [18:0] model(input logic s, input logic [15:0] x, y,
                                        input logic c);
    logic [15:0] yx;
    logic [16:0] full;
    logic        ov;
    yx   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yx} + {16'd0, c ^ s};
    ov   = (x[15] == yx[15]) && (full[15] != x[15]);
    return {full[15:0], full[16], ov, (full[15:0] == 16'd0)};
  endfunction

  // Issue one op on instance idx, scramble inputs after accept, and count busy cycles
  // until DONE. Returns -1 if DONE never arrives.
  task automatic do_op(input int idx, input logic s, input logic [15:0] x, y,
                       input logic c, output int lat);
    @(negedge clk);
    sub = s; a = x; b = y; cin = c; start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0; sub = ~s; a = ~x; b = ~y; cin = ~c;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[idx]) break;
      if (busy_v[idx]) lat++;
      @(negedge clk);
    end
    if (!done_v[idx]) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_v = 3'b111; sub = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({res_v[1], co_v[1], ov_v[1], z_v[1], busy_v[1], done_v[1]} !== 21'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got res=%h co=%b ov=%b z=%b busy=%b done=%b, want all 0",
                 i, res_v[1], co_v[1], ov_v[1], z_v[1], busy_v[1], done_v[1]);
      end
    end
    rst = 1'b0; start_v = 3'b000;
    @(negedge clk);
    checks++;
    if (busy_v !== 3'b000) begin
      failures++;
      $display("FAIL reset_start_ignored: got busy=%b, want 000", busy_v);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    do_op(1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL add_wrap_latency: got %0d, want 4", lat);
    end
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_wrap_result: got res=%h co=%b ov=%b z=%b, want 0000 1 0 1",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    @(negedge clk);
    checks++;
    if ({done_v[1], busy_v[1], res_v[1], z_v[1]} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL add_wrap_pulse: got done=%b busy=%b res=%h z=%b, want 0 0 0000 1",
               done_v[1], busy_v[1], res_v[1], z_v[1]);
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, lat);
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_overflow: got res=%h co=%b ov=%b z=%b, want 8000 0 1 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    do_op(1, 1'b1, 16'h8000, 16'h0001, 1'b0, lat);
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_overflow: got res=%h co=%b ov=%b z=%b, want 7fff 1 1 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(1, 1'b1, 16'h1234, 16'h1234, 1'b0, lat);
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_equal: got res=%h co=%b ov=%b z=%b, want 0000 1 0 1",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    do_op(1, 1'b1, 16'h0000, 16'h0001, 1'b0, lat);
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_borrow: got res=%h co=%b ov=%b z=%b, want ffff 0 0 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    do_op(1, 1'b1, 16'h0005, 16'h0002, 1'b1, lat);
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h0002, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub_borrow_in: got res=%h co=%b ov=%b z=%b, want 0002 1 0 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    sub = 1'b0; a = 16'h0100; b = 16'h0023; cin = 1'b0; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    lat = 1;
    @(negedge clk);
    // Second request while busy, with different operands.
    sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start_v[1] = 1'b1;
    lat++;
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[1]) break;
      if (busy_v[1]) lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 4 || done_v[1] !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore_latency: got %0d done=%b, want 4 1", lat, done_v[1]);
    end
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h0123, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL busy_ignore_result: got res=%h co=%b ov=%b z=%b, want 0123 0 0 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    @(negedge clk);
    checks++;
    if ({busy_v[1], done_v[1]} !== 2'b00) begin
      failures++;
      $display("FAIL busy_ignore_idle: got busy=%b done=%b, want 0 0", busy_v[1], done_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(1, 1'b0, 16'h1111, 16'h2222, 1'b1, lat);
    // Currently in the DONE cycle: request the next op now.
    sub = 1'b1; a = 16'h0010; b = 16'h0020; cin = 1'b0; start_v[1] = 1'b1;
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'h3334, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first: got res=%h co=%b ov=%b z=%b, want 3334 0 0 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
    @(negedge clk);
    start_v[1] = 1'b0; a = 16'hAAAA; b = 16'h5555;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_v[1]) break;
      if (busy_v[1]) lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 4 || done_v[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_latency: got %0d done=%b, want 4 1", lat, done_v[1]);
    end
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1]} !== {16'hFFF0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second: got res=%h co=%b ov=%b z=%b, want fff0 0 0 0",
               res_v[1], co_v[1], ov_v[1], z_v[1]);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    sub = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({res_v[1], co_v[1], ov_v[1], z_v[1], busy_v[1], done_v[1]} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got res=%h co=%b ov=%b z=%b busy=%b done=%b, want all 0",
               res_v[1], co_v[1], ov_v[1], z_v[1], busy_v[1], done_v[1]);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_v[1] || busy_v[1]) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", dones);
    end
  endtask

  task automatic test_sweep();
    int          lat;
    int          n_exp;
    logic        s, c;
    logic [15:0] x, y;
    logic [18:0] exp_v;
    for (int idx = 0; idx < 3; idx++) begin
      n_exp = (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
      for (int op = 0; op < 300; op++) begin
        s = 1'($urandom); c = 1'($urandom);
        x = 16'($urandom); y = 16'($urandom);
        if (op == 0) begin x = 16'h7FFF; y = 16'h7FFF; s = 1'b0; c = 1'b1; end
        exp_v = model(s, x, y, c);
        do_op(idx, s, x, y, c, lat);
        checks++;
        if (lat !== n_exp) begin
          failures++;
          $display("FAIL sweep_latency idx=%0d op=%0d: got %0d, want %0d", idx, op, lat, n_exp);
        end
        checks++;
        if ({res_v[idx], co_v[idx], ov_v[idx], z_v[idx]} !== exp_v) begin
          failures++;
          $display("FAIL sweep_result idx=%0d op=%0d s=%b a=%h b=%h c=%b: got %h %b%b%b, want %h %b%b%b",
                   idx, op, s, x, y, c, res_v[idx], co_v[idx], ov_v[idx], z_v[idx],
                   exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_overflow();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1);
  end

endmodule
